// File: rtl/vga_capture.sv
// Loopback capture of the 640x480 VGA stream back into the 16x12 grid word.
// Define CAPTURE_CHECK_EN to count r/g/b disagreement at the cell sample points.
module vga_capture #(
    parameter int PIXEL_LAT = 2,
    parameter int CELL      = 40,
    parameter int H_START   = 144,
    parameter int V_START   = 35,
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pixel_en,
    input  logic         hSync,
    input  logic         vSync,
    input  logic [3:0]   r,
    input  logic [3:0]   g,
    input  logic [3:0]   b,
    output logic [191:0] data,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err,
    output logic [7:0]   err_count
);
    localparam int COLS  = 16;
    localparam int ROWS  = 12;
    localparam int H0    = H_START + PIXEL_LAT;
    localparam int V_END = V_START + ROWS * CELL;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_r;
    logic          hs_r, vs_r, r3_r, v_pend_r;
    logic [9:0]    h_cnt_r, v_cnt_r;
    logic [191:0]  shadow_r;

    logic          h_fall_s, v_fall_s, v_clr_s, err_s, commit_s, sample_s;
    logic [9:0]    hx_s, vy_s;
    logic [3:0]    col_s, row_s;
    logic [7:0]    bit_idx_s;

    // Edge detection, timing checks and sample-point decode
    always_comb begin
        h_fall_s  = pixel_en & hs_r & ~hSync;
        v_fall_s  = pixel_en & vs_r & ~vSync;
        v_clr_s   = v_fall_s | v_pend_r;
        err_s     = (state_r != SEARCH) &&
                    ((h_fall_s && (h_cnt_r != 10'(H_TOTAL - 1))) ||
                     (v_fall_s && (v_cnt_r != 10'(V_TOTAL - 1))));
        commit_s  = (state_r == LOCKED) && h_fall_s && !v_clr_s &&
                    (v_cnt_r == 10'(V_END - 1)) && !err_s;
        hx_s      = h_cnt_r - 10'(H0);
        vy_s      = v_cnt_r - 10'(V_START);
        col_s     = 4'(hx_s / 10'(CELL));
        row_s     = 4'(vy_s / 10'(CELL));
        // row*16+col is just the concatenation of the two nibbles
        bit_idx_s = 8'd191 - {row_s, col_s};
        sample_s  = pixel_en && (state_r == LOCKED) &&
                    (h_cnt_r >= 10'(H0)) && (hx_s < 10'(COLS * CELL)) &&
                    (v_cnt_r >= 10'(V_START)) && (vy_s < 10'(ROWS * CELL)) &&
                    ((hx_s % 10'(CELL)) == 10'(CELL / 2)) &&
                    ((vy_s % 10'(CELL)) == 10'(CELL / 2));
    end

    // Input register, counters, lock FSM, shadow grid and commit
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            r3_r        <= 1'b0;
            v_pend_r    <= 1'b0;
            h_cnt_r     <= 10'd0;
            v_cnt_r     <= 10'd0;
            state_r     <= SEARCH;
            shadow_r    <= 192'h0;
            data        <= 192'h0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= (state_r == LOCKED);
            if (pixel_en) begin
                hs_r <= hSync;
                vs_r <= vSync;
                r3_r <= r[3];
                if (h_fall_s) begin
                    h_cnt_r <= 10'd0;
                end else if (h_cnt_r != 10'd1023) begin
                    h_cnt_r <= h_cnt_r + 10'd1;
                end
                // A vSync fall mid-line is remembered until the next line start
                if (h_fall_s) begin
                    if (v_clr_s) begin
                        v_cnt_r  <= 10'd0;
                        v_pend_r <= 1'b0;
                    end else if (v_cnt_r != 10'd1023) begin
                        v_cnt_r <= v_cnt_r + 10'd1;
                    end
                end else if (v_fall_s) begin
                    v_pend_r <= 1'b1;
                end
                if (err_s) begin
                    state_r  <= SEARCH;
                    sync_err <= 1'b1;
                end else begin
                    case (state_r)
                        SEARCH:  if (v_fall_s) state_r <= ALIGN;
                        ALIGN:   if (v_fall_s) state_r <= LOCKED;
                        LOCKED:  state_r <= LOCKED;
                        default: state_r <= SEARCH;
                    endcase
                end
                if (sample_s) begin
                    shadow_r[bit_idx_s] <= r3_r;
                end
                if (commit_s) begin
                    data        <= shadow_r;
                    frame_valid <= 1'b1;
                end
            end
        end
    end

`ifdef CAPTURE_CHECK_EN
    logic [2:0] r_lo_r;
    logic [3:0] g_r, b_r;

    function automatic logic chan_ok(input logic [3:0] rv, input logic [3:0] gv,
                                     input logic [3:0] bv);
        return (rv == gv) && (gv == bv) && ((rv == 4'h0) || (rv == 4'hF));
    endfunction

    // Channel agreement counter, saturating; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lo_r    <= 3'd0;
            g_r       <= 4'h0;
            b_r       <= 4'h0;
            err_count <= 8'h00;
        end else if (pixel_en) begin
            r_lo_r <= r[2:0];
            g_r    <= g;
            b_r    <= b;
            if (sample_s && !chan_ok({r3_r, r_lo_r}, g_r, b_r) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic unused_chan_s;
    assign unused_chan_s = ^{r[2:0], g, b};
    assign err_count     = 8'h00;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: a small display model drives reduced-geometry
// frames and hand-known grid patterns; outputs are compared at the falling edge.
module tb_vga_capture;
    localparam int CELL = 4;
    localparam int PL   = 2;
    localparam int HS   = 8;
    localparam int VS   = 3;
    localparam int HT   = 80;
    localparam int VT   = 55;
    localparam int HSW  = 4;
    localparam int VSW  = 2;
    localparam logic [191:0] PAT_A = {12{16'hAAAA}};
    localparam logic [191:0] PAT_S = {1'b1, 191'h0};
    localparam logic [191:0] PAT_1 = {192{1'b1}};
`ifdef CAPTURE_CHECK_EN
    localparam int ERR1 = 192;
    localparam int ERR2 = 255;
`else
    localparam int ERR1 = 0;
    localparam int ERR2 = 0;
`endif

    logic         clock, reset, pixel_en, hSync, vSync;
    logic [3:0]   r, g, b;
    logic [191:0] data;
    logic         frame_valid, locked, sync_err;
    logic [7:0]   err_count;

    int total, bad, cyc, fv_cnt, se_cnt, fv_t_last, fv_t_prev;

    vga_capture #(
        .PIXEL_LAT(PL), .CELL(CELL), .H_START(HS), .V_START(VS),
        .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clock(clock), .reset(reset), .pixel_en(pixel_en),
        .hSync(hSync), .vSync(vSync), .r(r), .g(g), .b(b),
        .data(data), .frame_valid(frame_valid), .locked(locked),
        .sync_err(sync_err), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_t_prev = fv_t_last;
            fv_t_last = cyc;
        end
        if (sync_err === 1'b1) se_cnt++;
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One frame from the display model; negative line numbers disable the specials.
    task automatic drive_frame(input logic [191:0] pat, input int short_line,
                               input int gate_line, input int rst_line, input bit g0);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                int  xi, yi;
                bit  act;
                logic px;
                @(posedge clock); #1;
                if (l == gate_line && p == 30) begin
                    pixel_en = 1'b0;
                    repeat (100) @(posedge clock);
                    #1;
                    pixel_en = 1'b1;
                end
                hSync = (p >= HSW);
                vSync = (l >= VSW);
                xi  = p - HS - PL;
                yi  = l - VS;
                act = (xi >= 0) && (xi < 16 * CELL) && (yi >= 0) && (yi < 12 * CELL);
                px  = act ? pat[191 - ((yi / CELL) * 16 + xi / CELL)] : 1'b0;
                if (g0 && act) begin
                    r = 4'hF; g = 4'h0; b = 4'hF;
                end else begin
                    r = px ? 4'hF : 4'h0;
                    g = r;
                    b = r;
                end
                if (l == rst_line && p == 0) begin
                    reset = 1'b1;
                    @(posedge clock); #1;
                    reset = 1'b0;
                    chk("midrst_data", data, 192'h0);
                    chk("midrst_locked", {191'h0, locked}, 192'h0);
                    chk("midrst_fv", {191'h0, frame_valid}, 192'h0);
                    chk("midrst_serr", {191'h0, sync_err}, 192'h0);
                    chk("midrst_errcnt", {184'h0, err_count}, 192'h0);
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; fv_cnt = 0; se_cnt = 0; fv_t_last = 0; fv_t_prev = 0;
        reset = 1'b1; pixel_en = 1'b1; hSync = 1'b1; vSync = 1'b1;
        r = 4'h0; g = 4'h0; b = 4'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_data", data, 192'h0);
        chk("rst_locked", {191'h0, locked}, 192'h0);
        chk("rst_fv", {191'h0, frame_valid}, 192'h0);
        chk("rst_serr", {191'h0, sync_err}, 192'h0);
        chk("rst_errcnt", {184'h0, err_count}, 192'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("align_locked", {191'h0, locked}, 192'h0);
        chk("align_fvcnt", 192'(fv_cnt), 192'd0);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("first_fvcnt", 192'(fv_cnt), 192'd1);
        chk("first_data", data, PAT_A);
        chk("first_locked", {191'h0, locked}, 192'h1);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("second_fvcnt", 192'(fv_cnt), 192'd2);
        chk("fv_period", 192'(fv_t_last - fv_t_prev), 192'(HT * VT));
        chk("second_data", data, PAT_A);

        drive_frame(PAT_S, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("single_data", data, PAT_S);
        chk("single_b191", {191'h0, data[191]}, 192'h1);
        chk("single_b176", {191'h0, data[176]}, 192'h0);
        chk("single_b190", {191'h0, data[190]}, 192'h0);
        chk("single_fvcnt", 192'(fv_cnt), 192'd3);

        drive_frame(PAT_A, 10, -1, -1, 1'b0);
        @(negedge clock);
        chk("short_secnt", 192'(se_cnt), 192'd1);
        chk("short_fvcnt", 192'(fv_cnt), 192'd3);
        chk("short_locked", {191'h0, locked}, 192'h0);
        chk("short_data", data, PAT_S);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("realign_fvcnt", 192'(fv_cnt), 192'd3);
        chk("realign_locked", {191'h0, locked}, 192'h0);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("relock_fvcnt", 192'(fv_cnt), 192'd4);
        chk("relock_data", data, PAT_A);
        chk("relock_locked", {191'h0, locked}, 192'h1);
        chk("relock_secnt", 192'(se_cnt), 192'd1);

        drive_frame(PAT_S, -1, 20, -1, 1'b0);
        @(negedge clock);
        chk("gate_secnt", 192'(se_cnt), 192'd1);
        chk("gate_fvcnt", 192'(fv_cnt), 192'd5);
        chk("gate_data", data, PAT_S);

        drive_frame(PAT_A, -1, -1, 30, 1'b0);
        @(negedge clock);
        chk("postrst_data", data, 192'h0);
        chk("postrst_fvcnt", 192'(fv_cnt), 192'd5);
        chk("postrst_locked", {191'h0, locked}, 192'h0);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("rstalign_data", data, 192'h0);
        chk("rstalign_fvcnt", 192'(fv_cnt), 192'd5);

        drive_frame(PAT_A, -1, -1, -1, 1'b0);
        @(negedge clock);
        chk("rstlock_data", data, PAT_A);
        chk("rstlock_fvcnt", 192'(fv_cnt), 192'd6);

        drive_frame(PAT_A, -1, -1, -1, 1'b1);
        @(negedge clock);
        chk("g0_data", data, PAT_1);
        chk("g0_errcnt1", {184'h0, err_count}, 192'(ERR1));

        drive_frame(PAT_A, -1, -1, -1, 1'b1);
        @(negedge clock);
        chk("g0_errcnt2", {184'h0, err_count}, 192'(ERR2));
        chk("final_secnt", 192'(se_cnt), 192'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
